// File: rtl/cpu_pkg.sv
// Shared types and constants for the LEGv8 core front end.
// No logic of its own; imported by the fetch unit and its helpers.
// No latency or backpressure of its own.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 64;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BR   = 2'b10;
    localparam logic [1:0] PS_REG  = 2'b11;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        EXEC  = 2'd3
    } ifu_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selector with alignment and ROM-range checking.
// Purely combinational, zero latency.
// No backpressure; the caller decides when to load the result.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int ROM_AW = 8
) (
    input  logic [PC_W-1:0] pc,
    input  logic [1:0]      ps,
    input  logic [PC_W-1:0] pc_offset,
    input  logic [PC_W-1:0] pc_reg,
    output logic [PC_W-1:0] pc_next,
    output logic            fault
);

    logic [PC_W-1:0] target;
    logic            misaligned;
    logic            out_of_range;

    always_comb begin
        target = pc;
        case (ps)
            PS_INC:  target = pc + 64'd4;
            PS_BR:   target = pc + (pc_offset << 2);
            PS_REG:  target = pc_reg;
            default: target = pc;
        endcase
    end

    // The ROM only decodes the low address bits; high bits still load into pc.
    assign misaligned   = |target[1:0];
    assign out_of_range = |target[PC_W-1:ROM_AW+2];
    assign pc_next      = {target[PC_W-1:2], 2'b00};
    assign fault        = misaligned | out_of_range;

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter owner: fetches LEGv8 words from ROM and hands them to control.
// Fetch-to-valid ROM_LAT+1 cycles; one instruction per ROM_LAT+3 cycles.
// Holds instr while instr_ready=0; waits in EXEC for ps_valid. IFU_RETIRE_COUNT_EN adds retired.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              ROM_AW   = 8,
    parameter int              ROM_LAT  = 1,
    parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               rom_en,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic [1:0]         ps,
    input  logic               ps_valid,
    input  logic [PC_W-1:0]    pc_offset,
    input  logic [PC_W-1:0]    pc_reg,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_plus4,
    output logic               fault
`ifdef IFU_RETIRE_COUNT_EN
    ,
    output logic [31:0]        retired
`endif
);

    localparam logic [1:0] LAT_LAST = 2'(ROM_LAT - 1);

    ifu_state_t      state, state_nxt;
    logic            armed;
    logic [1:0]      lat_cnt;
    logic            last_beat;
    logic            take_ps;
    logic [PC_W-1:0] pc_next;
    logic            calc_fault;

    pc_next_calc #(.ROM_AW(ROM_AW)) u_pc_next_calc (
        .pc        (pc),
        .ps        (ps),
        .pc_offset (pc_offset),
        .pc_reg    (pc_reg),
        .pc_next   (pc_next),
        .fault     (calc_fault)
    );

    assign last_beat = (lat_cnt == LAT_LAST);
    assign take_ps   = (state == EXEC) && ps_valid;
    assign rom_addr  = pc[ROM_AW+1:2];
    assign pc_plus4  = pc + 64'd4;

    // armed keeps rom_en low in the first cycle after reset even though state is FETCH.
    always_comb begin
        state_nxt = state;
        rom_en    = 1'b0;
        case (state)
            FETCH: begin
                if (armed) begin
                    rom_en    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (last_beat) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (instr_valid && instr_ready) state_nxt = EXEC;
            end
            EXEC: begin
                if (ps_valid) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            armed       <= 1'b0;
            lat_cnt     <= 2'd0;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc          <= RESET_PC;
            fault       <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;

            if (state == WAIT && !last_beat) lat_cnt <= lat_cnt + 2'd1;
            else                             lat_cnt <= 2'd0;

            if (state == WAIT && last_beat) begin
                instr       <= rom_data;
                instr_valid <= 1'b1;
            end else if (state == ISSUE && instr_ready) begin
                instr_valid <= 1'b0;
            end

            if (take_ps) begin
                pc <= pc_next;
                if (calc_fault) fault <= 1'b1;
            end
        end
    end

`ifdef IFU_RETIRE_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired <= 32'd0;
        end else if (take_ps && ps != PS_HOLD) begin
            retired <= retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle synchronous ROM model.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  ps;
    logic        ps_valid;
    logic [63:0] pc_offset;
    logic [63:0] pc_reg;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic        fault;
`ifdef IFU_RETIRE_COUNT_EN
    logic [31:0] retired;
`endif

    logic [31:0] rom [0:255];
    int vec_cnt = 0;
    int err_cnt = 0;

    instr_fetch_unit #(.ROM_AW(8), .ROM_LAT(1), .RESET_PC(64'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ps          (ps),
        .ps_valid    (ps_valid),
        .pc_offset   (pc_offset),
        .pc_reg      (pc_reg),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fault       (fault)
`ifdef IFU_RETIRE_COUNT_EN
        ,
        .retired     (retired)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int n = 0; n < 20 && !instr_valid; n++) tick();
        check(tag, instr_valid, 1);
    endtask

    task automatic wait_fetch(input string tag);
        for (int n = 0; n < 20 && !rom_en; n++) tick();
        check(tag, rom_en, 1);
    endtask

    // Handshake the pending word, then answer in EXEC; returns in the next FETCH.
    task automatic issue(input logic [1:0] p, input logic [63:0] off, input logic [63:0] r);
        wait_valid("issue_vld");
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        ps          = p;
        pc_offset   = off;
        pc_reg      = r;
        ps_valid    = 1'b1;
        tick();
        ps_valid    = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 | 32'(i);
        rom[0] = 32'h9101_9004;
        rom_data    = 32'h0;
        rst         = 1'b0;
        instr_ready = 1'b0;
        ps          = PS_HOLD;
        ps_valid    = 1'b0;
        pc_offset   = 64'h0;
        pc_reg      = 64'h0;

        repeat (2) tick();
        check("rst_pc", pc, 64'h0);
        check("rst_vld", instr_valid, 0);
        check("rst_rom_en", rom_en, 0);
        check("rst_fault", fault, 0);
        check("rst_instr", instr, 32'h0);
`ifdef IFU_RETIRE_COUNT_EN
        check("rst_retired", retired, 0);
`endif

        // First fetch: cycle 0 idle, rom_en in cycle 1, valid in cycle 3.
        rst = 1'b1;
        check("c0_rom_en", rom_en, 0);
        tick();
        check("c1_rom_en", rom_en, 1);
        check("c1_rom_addr", rom_addr, 8'h00);
        tick();
        check("c2_rom_en", rom_en, 0);
        check("c2_vld", instr_valid, 0);
        tick();
        check("c3_vld", instr_valid, 1);
        check("c3_instr", instr, 32'h9101_9004);
        instr_ready = 1'b1;
        ps          = PS_INC;
        ps_valid    = 1'b1;
        tick();
        check("c4_pc_ignored_in_issue", pc, 64'h0);
        check("c4_vld_clr", instr_valid, 0);
        tick();
        ps_valid    = 1'b0;
        instr_ready = 1'b0;
        check("inc_pc", pc, 64'h4);
        check("inc_pc_plus4", pc_plus4, 64'h8);
        check("inc_rom_en", rom_en, 1);
        check("inc_rom_addr", rom_addr, 8'h01);

        // Backpressure: word held, no refetch.
        wait_valid("bp_vld");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_vld_hold", instr_valid, 1);
            check("bp_instr_hold", instr, 32'hA000_0001);
            check("bp_no_fetch", rom_en, 0);
        end

        issue(PS_REG, 64'h0, 64'h20);
        check("reg20_pc", pc, 64'h20);
        check("reg20_fault", fault, 0);
        check("reg20_addr", rom_addr, 8'h08);

        issue(PS_BR, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0);
        check("br_m7_pc", pc, 64'h4);
        check("br_m7_fault", fault, 0);

        issue(PS_REG, 64'h0, 64'h0);
        check("reg0_pc", pc, 64'h0);

        issue(PS_BR, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        check("br_m1_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("br_m1_fault", fault, 1);
        check("br_m1_addr", rom_addr, 8'hFF);

        // Asynchronous reset while in EXEC.
        wait_valid("wrap_vld");
        check("wrap_instr", instr, 32'hA000_00FF);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("exec_rst_pc", pc, 64'h0);
        check("exec_rst_fault", fault, 0);
        check("exec_rst_rom_en", rom_en, 0);
        check("exec_rst_instr", instr, 32'h0);
        tick();
        rst = 1'b1;
        wait_fetch("exec_rst_refetch");
        check("exec_rst_addr", rom_addr, 8'h00);

        issue(PS_REG, 64'h0, 64'h13);
        check("reg13_pc", pc, 64'h10);
        check("reg13_fault", fault, 1);
        for (int i = 0; i < 10; i++) begin
            issue(PS_INC, 64'h0, 64'h0);
            check("fault_sticky", fault, 1);
        end
        check("after10_pc", pc, 64'h38);

        for (int i = 0; i < 3; i++) begin
            wait_valid("hold_vld");
            check("hold_instr", instr, 32'hA000_000E);
            issue(PS_HOLD, 64'h0, 64'h0);
            check("hold_pc", pc, 64'h38);
            check("hold_rom_en", rom_en, 1);
            check("hold_addr", rom_addr, 8'h0E);
        end
`ifdef IFU_RETIRE_COUNT_EN
        check("hold_retired", retired, 11);
`endif
        issue(PS_INC, 64'h0, 64'h0);
        check("post_hold_pc", pc, 64'h3C);
`ifdef IFU_RETIRE_COUNT_EN
        check("inc_retired", retired, 12);
`endif

        // Asynchronous reset while in WAIT.
        tick();
        check("wait_rom_en", rom_en, 0);
        #2 rst = 1'b0;
        #1;
        check("wait_rst_pc", pc, 64'h0);
        check("wait_rst_instr", instr, 32'h0);
        check("wait_rst_vld", instr_valid, 0);
        check("wait_rst_fault", fault, 0);
        tick();
        rst = 1'b1;
        wait_fetch("wait_rst_refetch");
        check("wait_rst_addr", rom_addr, 8'h00);
        wait_valid("wait_rst_vld2");
        check("wait_rst_instr2", instr, 32'h9101_9004);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Owns the program counter, reads 32-bit LEGv8 words from the instruction ROM, and presents each word to the control unit with a valid/ready handshake.
- Waits for the control unit to return its PC-select (PS) code, then updates the PC and fetches the next word.
- Sits between the instruction ROM and the control unit. It is the producer side of the control unit's instruction input and the consumer of controlWord[31:30] plus the constant.

Parameters:
- ROM_AW, 8, ROM word-address width; the ROM holds 2^ROM_AW words.
- ROM_LAT, 1, ROM read latency in cycles, from rom_en to rom_data valid; range 1..3.
- RESET_PC, 64'h0, PC value after reset; must be 4-byte aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (rst=0 resets).
- rom_en  out  1  ROM read strobe, one cycle per fetch.
- rom_addr  out  ROM_AW  word address = pc[ROM_AW+1:2].
- rom_data  in  32  ROM read data, valid ROM_LAT cycles after rom_en.
- instr  out  32  instruction to the control unit.
- instr_valid  out  1  instr holds a fetched word.
- instr_ready  in  1  control unit accepts instr.
- ps  in  2  PC select: 00 hold, 01 +4, 10 branch, 11 register.
- ps_valid  in  1  ps, pc_offset and pc_reg are valid this cycle.
- pc_offset  in  64  sign-extended branch offset, in words.
- pc_reg  in  64  jump target for ps=11, a register A value.
- pc  out  64  current PC.
- pc_plus4  out  64  pc+4, combinational; feeds the EN_PC path.
- fault  out  1  sticky: misaligned or out-of-range target.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, rom_en=0, fault=0.
  - Applies immediately mid-operation; any in-flight ROM read is discarded.
- FSM states: FETCH, WAIT, ISSUE, EXEC.
- FETCH: rom_en=1 for exactly one cycle, rom_addr from pc. Next state is WAIT.
- WAIT: counts ROM_LAT cycles. On the last count, instr<=rom_data and instr_valid<=1, then go to ISSUE.
  - Fetch-to-valid latency = ROM_LAT+1 cycles after FETCH.
- ISSUE:
  - instr and instr_valid are held stable while instr_ready=0.
  - On instr_valid&&instr_ready: instr_valid<=0, go to EXEC.
  - ps_valid is ignored in ISSUE, even if asserted in the same cycle as the handshake.
- EXEC: waits for ps_valid. On ps_valid, load pc and go to FETCH:
  - 00: pc unchanged; the same word is refetched.
  - 01: pc+4.
  - 10: pc+(pc_offset<<2).
  - 11: pc_reg.
- Arithmetic: all 64-bit modulo 2^64. Wrap-around is legal (0xFFFF_FFFF_FFFF_FFFC +4 -> 0).
- Target checks (applied before the pc load):
  - If target[1:0]!=0: target[1:0] is forced to 0 and fault is set.
  - If target[63:ROM_AW+2]!=0: fault is set, and pc still loads the full value. rom_addr uses the low bits only.
- fault clears only on reset.
- Outside FETCH, rom_en=0 and rom_addr holds the last value.
- Throughput: one instruction per ROM_LAT+3 cycles when ready and ps_valid are asserted promptly.

Optional Feature:
- Macro: IFU_RETIRE_COUNT_EN.
- Defined:
  - Adds output port retired[31:0], reset 0.
  - Increments by 1 on each EXEC->FETCH transition with ps!=00, wrapping at 2^32.
  - A hold (ps=00) does not count.
- Not defined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Shared package (cpu_pkg):
  - PS encodings PS_HOLD=2'b00, PS_INC=2'b01, PS_BR=2'b10, PS_REG=2'b11.
  - FSM state enum ifu_state_t.
  - Constants INSTR_W=32 and PC_W=64.
- Sub-module pc_next_calc: combinational. Computes the next pc and the fault condition from pc, ps, pc_offset and pc_reg. Verified standalone.

Test Plan:
- Reset release, ROM[0]=32'h91019004 (addi), instr_ready=1 -> rom_en at cycle 1, instr_valid at cycle 1+ROM_LAT+1, instr=91019004.
- Then ps=01 in EXEC -> pc=4, next rom_addr=1. Hold instr_ready=0 for 5 cycles -> instr stable and no refetch.
- pc=0x20, ps=10, pc_offset=-7 (64'hFFFF_FFFF_FFFF_FFF9) -> pc=0x04. A second case with pc=0, offset -1 -> pc=0xFFFF_FFFF_FFFF_FFFC and fault=1 (out of range).
- ps=11, pc_reg=0x13 -> pc=0x10 and fault=1, and fault remains 1 through 10 further fetches.
- ps=00 three times -> the same rom_addr is refetched three times and pc is unchanged. With IFU_RETIRE_COUNT_EN, retired is unchanged; after one ps=01, retired increments by 1.
- rst=0 asserted during WAIT and during EXEC -> outputs clear in the same cycle without a clock edge. After release, the first fetch is at RESET_PC.
